// File: rtl/sal_cmd_sched_pkg.sv
// Shared DDR command package: command encoding, command field types and
// the width used for all timing values handed to the scheduler.
package sal_ddr_pkg;

    localparam int TIM_W = 8;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } dram_cmd_t;

    typedef logic [2:0]       dram_ba_t;
    typedef logic [15:0]      dram_ra_t;
    typedef logic [9:0]       dram_ca_t;
    typedef logic [3:0]       dram_id_t;
    typedef logic [3:0]       dram_len_t;
    typedef logic [TIM_W-1:0] tim_t;

endpackage

// File: rtl/sal_cmd_sched_if.sv
// Interfaces of the command scheduler: timing parameters (driven by the
// configuration block, monitored by the scheduler) and the per-bank
// request/grant channel between a bank controller and the scheduler.
interface sal_timing_if;
    import sal_ddr_pkg::*;

    tim_t t_rrd_m1;
    tim_t t_ccd_m1;
    tim_t t_wtr_m1;
    tim_t t_rtw_m1;
    tim_t t_faw_m1;

    modport drv (output t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1, t_faw_m1);
    modport mon (input  t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1, t_faw_m1);
endinterface

interface sal_sched_if;
    import sal_ddr_pkg::*;

    logic      act_req, rd_req, wr_req, pre_req, ref_req;
    dram_ba_t  ba;
    dram_ra_t  ra;
    dram_ca_t  ca;
    dram_id_t  id;
    dram_len_t len;
    logic      act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;

    modport src (output act_req, rd_req, wr_req, pre_req, ref_req,
                 output ba, ra, ca, id, len,
                 input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt);
    modport dst (input  act_req, rd_req, wr_req, pre_req, ref_req,
                 input  ba, ra, ca, id, len,
                 output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt);
endinterface

// File: rtl/sal_timing_cntr.sv
// Timing down-counter: loads on request (even when still running),
// otherwise counts down to zero and holds. busy is high while nonzero.
module sal_timing_cntr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy
);

    logic [W-1:0] cnt;

    // Reload on grant, otherwise saturating decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/sal_cmd_sched.sv
// DRAM command scheduler: picks at most one command per cycle across all
// bank controllers (RD/WR > ACT > PRE > REF, round-robin within a class),
// enforces tRRD/tCCD/tWTR/tRTW, and registers the issued command.
// Optional tFAW window tracking is built when SAL_TFAW_EN is defined.
module sal_cmd_sched
    import sal_ddr_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int FAW_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    sal_timing_if.mon timing_if,
    sal_sched_if.dst  sched_if [NUM_BANKS],
    output logic      cmd_valid_o,
    output dram_cmd_t cmd_o,
    output dram_ba_t  cmd_ba_o,
    output dram_ra_t  cmd_ra_o,
    output dram_ca_t  cmd_ca_o,
    output dram_id_t  cmd_id_o,
    output dram_len_t cmd_len_o
);

    localparam int PW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [NUM_BANKS-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
    logic [NUM_BANKS-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    dram_ba_t  ba_a  [NUM_BANKS];
    dram_ra_t  ra_a  [NUM_BANKS];
    dram_ca_t  ca_a  [NUM_BANKS];
    dram_id_t  id_a  [NUM_BANKS];
    dram_len_t len_a [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign act_req[b] = sched_if[b].act_req;
        assign rd_req[b]  = sched_if[b].rd_req;
        assign wr_req[b]  = sched_if[b].wr_req;
        assign pre_req[b] = sched_if[b].pre_req;
        assign ref_req[b] = sched_if[b].ref_req;
        assign ba_a[b]    = sched_if[b].ba;
        assign ra_a[b]    = sched_if[b].ra;
        assign ca_a[b]    = sched_if[b].ca;
        assign id_a[b]    = sched_if[b].id;
        assign len_a[b]   = sched_if[b].len;
        assign sched_if[b].act_gnt = act_gnt[b];
        assign sched_if[b].rd_gnt  = rd_gnt[b];
        assign sched_if[b].wr_gnt  = wr_gnt[b];
        assign sched_if[b].pre_gnt = pre_gnt[b];
        assign sched_if[b].ref_gnt = ref_gnt[b];
    end

    logic          rrd_busy, ccd_busy, wtr_busy, rtw_busy, faw_ok;
    logic          rd_ok, wr_ok, act_ok, ref_ok;
    logic [NUM_BANKS-1:0] rdwr_cand, act_cand, pre_cand, ref_cand, cand;
    dram_cmd_t     cls_cmd, gnt_cmd;
    logic          pick_hit, gnt_vld;
    logic [PW-1:0] gnt_bank, rr_ptr;

    assign rd_ok  = !ccd_busy && !wtr_busy;
    assign wr_ok  = !ccd_busy && !rtw_busy;
    assign act_ok = !rrd_busy && faw_ok;
    // REF waits until nobody wants to open a row or move data, blocked or not.
    assign ref_ok = !(|act_req) && !(|rd_req) && !(|wr_req);

    assign rdwr_cand = (rd_req & {NUM_BANKS{rd_ok}}) | (wr_req & {NUM_BANKS{wr_ok}});
    assign act_cand  = act_req & {NUM_BANKS{act_ok}};
    assign pre_cand  = pre_req;
    assign ref_cand  = ref_req & {NUM_BANKS{ref_ok}};

    // Highest class with an eligible bank wins, then round-robin from rr_ptr.
    always_comb begin
        int idx;
        cand     = '0;
        cls_cmd  = CMD_NOP;
        pick_hit = 1'b0;
        gnt_bank = '0;
        idx      = 0;
        if (|rdwr_cand) begin
            cand    = rdwr_cand;
            cls_cmd = CMD_RD;
        end else if (|act_cand) begin
            cand    = act_cand;
            cls_cmd = CMD_ACT;
        end else if (|pre_cand) begin
            cand    = pre_cand;
            cls_cmd = CMD_PRE;
        end else if (|ref_cand) begin
            cand    = ref_cand;
            cls_cmd = CMD_REF;
        end
        for (int k = 0; k < NUM_BANKS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_BANKS) idx = idx - NUM_BANKS;
            if (!pick_hit && cand[idx[PW-1:0]]) begin
                pick_hit = 1'b1;
                gnt_bank = idx[PW-1:0];
            end
        end
        // A bank asking for both RD and WR gets the RD when it is allowed.
        gnt_cmd = cls_cmd;
        if (cls_cmd == CMD_RD && !(rd_req[gnt_bank] && rd_ok)) gnt_cmd = CMD_WR;
    end

    assign gnt_vld = pick_hit && rst_n;

    // Decode the single winner into the one-hot per-type grant vectors.
    always_comb begin
        act_gnt = '0;
        rd_gnt  = '0;
        wr_gnt  = '0;
        pre_gnt = '0;
        ref_gnt = '0;
        if (gnt_vld) begin
            case (gnt_cmd)
                CMD_ACT: act_gnt[gnt_bank] = 1'b1;
                CMD_RD:  rd_gnt[gnt_bank]  = 1'b1;
                CMD_WR:  wr_gnt[gnt_bank]  = 1'b1;
                CMD_PRE: pre_gnt[gnt_bank] = 1'b1;
                CMD_REF: ref_gnt[gnt_bank] = 1'b1;
                default: ;
            endcase
        end
    end

    // Next search starts at the bank after the last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (gnt_vld) begin
            rr_ptr <= (gnt_bank == PW'(NUM_BANKS - 1)) ? '0 : gnt_bank + PW'(1);
        end
    end

    sal_timing_cntr #(.W(TIM_W)) u_rrd (
        .clk(clk), .rst_n(rst_n),
        .load(gnt_vld && gnt_cmd == CMD_ACT),
        .load_val(timing_if.t_rrd_m1), .busy(rrd_busy));

    sal_timing_cntr #(.W(TIM_W)) u_ccd (
        .clk(clk), .rst_n(rst_n),
        .load(gnt_vld && (gnt_cmd == CMD_RD || gnt_cmd == CMD_WR)),
        .load_val(timing_if.t_ccd_m1), .busy(ccd_busy));

    sal_timing_cntr #(.W(TIM_W)) u_wtr (
        .clk(clk), .rst_n(rst_n),
        .load(gnt_vld && gnt_cmd == CMD_WR),
        .load_val(timing_if.t_wtr_m1), .busy(wtr_busy));

    sal_timing_cntr #(.W(TIM_W)) u_rtw (
        .clk(clk), .rst_n(rst_n),
        .load(gnt_vld && gnt_cmd == CMD_RD),
        .load_val(timing_if.t_rtw_m1), .busy(rtw_busy));

`ifdef SAL_TFAW_EN
    logic [FAW_DEPTH-1:0] faw_busy, faw_load;

    // Each ACT claims the lowest idle window slot.
    always_comb begin
        logic faw_hit;
        faw_load = '0;
        faw_hit  = 1'b0;
        for (int s = 0; s < FAW_DEPTH; s++) begin
            if (!faw_hit && !faw_busy[s]) begin
                faw_hit     = 1'b1;
                faw_load[s] = gnt_vld && gnt_cmd == CMD_ACT;
            end
        end
    end

    for (genvar s = 0; s < FAW_DEPTH; s++) begin : g_faw
        sal_timing_cntr #(.W(TIM_W)) u_faw (
            .clk(clk), .rst_n(rst_n),
            .load(faw_load[s]),
            .load_val(timing_if.t_faw_m1), .busy(faw_busy[s]));
    end

    assign faw_ok = !(&faw_busy);
`else
    logic unused_faw;
    assign unused_faw = ^{timing_if.t_faw_m1, {FAW_DEPTH{1'b0}}};
    assign faw_ok     = 1'b1;
`endif

    // Register the granted command; reset discards anything pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_o <= 1'b0;
            cmd_o       <= CMD_NOP;
            cmd_ba_o    <= '0;
            cmd_ra_o    <= '0;
            cmd_ca_o    <= '0;
            cmd_id_o    <= '0;
            cmd_len_o   <= '0;
        end else begin
            cmd_valid_o <= gnt_vld;
            if (gnt_vld) begin
                cmd_o     <= gnt_cmd;
                cmd_ba_o  <= ba_a[gnt_bank];
                cmd_ra_o  <= ra_a[gnt_bank];
                cmd_ca_o  <= ca_a[gnt_bank];
                cmd_id_o  <= id_a[gnt_bank];
                cmd_len_o <= len_a[gnt_bank];
            end else begin
                cmd_o     <= CMD_NOP;
            end
        end
    end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Self-checking bench for sal_cmd_sched: a vector table for arbitration
// plus hand-written timing sequences. Expected commands go into a queue
// when the grant is checked and are compared when the registered output
// appears one cycle later.
module tb_sal_cmd_sched;
    import sal_ddr_pkg::*;

    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sal_timing_if tif ();
    sal_sched_if  sif [NB] ();

    logic [NB-1:0] act_v, rd_v, wr_v, pre_v, ref_v;
    logic [NB-1:0] act_g, rd_g, wr_g, pre_g, ref_g;

    logic      cmd_valid;
    dram_cmd_t cmd;
    dram_ba_t  cmd_ba;
    dram_ra_t  cmd_ra;
    dram_ca_t  cmd_ca;
    dram_id_t  cmd_id;
    dram_len_t cmd_len;

    for (genvar b = 0; b < NB; b++) begin : g_b
        assign sif[b].act_req = act_v[b];
        assign sif[b].rd_req  = rd_v[b];
        assign sif[b].wr_req  = wr_v[b];
        assign sif[b].pre_req = pre_v[b];
        assign sif[b].ref_req = ref_v[b];
        assign sif[b].ba      = dram_ba_t'(b);
        assign sif[b].ra      = dram_ra_t'(32'h1A0 + b);
        assign sif[b].ca      = dram_ca_t'(32'h050 + b);
        assign sif[b].id      = dram_id_t'(b + 3);
        assign sif[b].len     = dram_len_t'(b + 1);
        assign act_g[b] = sif[b].act_gnt;
        assign rd_g[b]  = sif[b].rd_gnt;
        assign wr_g[b]  = sif[b].wr_gnt;
        assign pre_g[b] = sif[b].pre_gnt;
        assign ref_g[b] = sif[b].ref_gnt;
    end

    sal_cmd_sched #(.NUM_BANKS(NB), .FAW_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .timing_if(tif), .sched_if(sif),
        .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_ba_o(cmd_ba),
        .cmd_ra_o(cmd_ra), .cmd_ca_o(cmd_ca), .cmd_id_o(cmd_id),
        .cmd_len_o(cmd_len));

    typedef struct {
        logic [3:0] act, rd, wr, pre, rf;
        dram_cmd_t  cmd;
        int         bank;
    } vec_t;

    typedef struct {
        dram_cmd_t cmd;
        int        bank;
    } exp_t;

    vec_t tbl [14];
    exp_t sbq [$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [19:0] exp_gnt(input dram_cmd_t c, input int b);
        logic [3:0]  oh;
        logic [19:0] v;
        oh = 4'b0001 << b;
        v  = '0;
        case (c)
            CMD_ACT: v[19:16] = oh;
            CMD_RD:  v[15:12] = oh;
            CMD_WR:  v[11:8]  = oh;
            CMD_PRE: v[7:4]   = oh;
            CMD_REF: v[3:0]   = oh;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [39:0] exp_fields(input exp_t e);
        return {e.cmd, 3'(e.bank), 16'(32'h1A0 + e.bank), 10'(32'h050 + e.bank),
                4'(e.bank + 3), 4'(e.bank + 1)};
    endfunction

    task automatic check_out();
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("cmd_valid", 64'(cmd_valid), 64'd1);
            check("cmd_fields", 64'({cmd, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len}),
                  64'(exp_fields(e)));
        end else begin
            check("cmd_idle", 64'(cmd_valid), 64'd0);
        end
    endtask

    task automatic set_req(input logic [3:0] a, r, w, p, f);
        act_v = a; rd_v = r; wr_v = w; pre_v = p; ref_v = f;
    endtask

    // One scheduler cycle: check last cycle's output, drive, check grant.
    task automatic step(input logic [3:0] a, r, w, p, f,
                        input dram_cmd_t c, input int b, input string tag);
        @(posedge clk); #1;
        check_out();
        set_req(a, r, w, p, f);
        @(negedge clk);
        check(tag, 64'({act_g, rd_g, wr_g, pre_g, ref_g}), 64'(exp_gnt(c, b)));
        if (c != CMD_NOP) sbq.push_back('{c, b});
    endtask

    task automatic set_tim(input int rrd, ccd, wtr, rtw, faw);
        tif.t_rrd_m1 = tim_t'(rrd);
        tif.t_ccd_m1 = tim_t'(ccd);
        tif.t_wtr_m1 = tim_t'(wtr);
        tif.t_rtw_m1 = tim_t'(rtw);
        tif.t_faw_m1 = tim_t'(faw);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_req('0, '0, '0, '0, '0);
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, CMD_ACT, 0};
        tbl[1]  = '{4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0000, CMD_WR,  2};
        tbl[2]  = '{4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, CMD_RD,  0};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, CMD_PRE, 1};
        tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, CMD_REF, 0};
        tbl[5]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0011, CMD_ACT, 2};
        tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b1111, CMD_PRE, 1};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001, CMD_REF, 3};
        tbl[8]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, CMD_RD,  1};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, CMD_NOP, 0};
        tbl[10] = '{4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b0000, CMD_WR,  3};
        tbl[11] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, CMD_RD,  0};
        tbl[12] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, CMD_ACT, 1};
        tbl[13] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0100, CMD_RD,  3};

        // Reset state, with requests present to show grants are held off.
        rst_n = 1'b0;
        set_tim(0, 0, 0, 0, 0);
        set_req('1, '1, '1, '1, '1);
        @(negedge clk);
        check("rst_grants", 64'({act_g, rd_g, wr_g, pre_g, ref_g}), 64'd0);
        check("rst_outputs", 64'({cmd_valid, cmd, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len}), 64'd0);
        do_reset();

        // Arbitration table, all timing constraints zero.
        for (int i = 0; i < 14; i++)
            step(tbl[i].act, tbl[i].rd, tbl[i].wr, tbl[i].pre, tbl[i].rf,
                 tbl[i].cmd, tbl[i].bank, $sformatf("tbl_gnt_%0d", i));
        step('0, '0, '0, '0, '0, CMD_NOP, 0, "tbl_flush");

        // tRRD=3: second ACT waits four cycles; PRE slips past the blocked ACT.
        do_reset();
        set_tim(3, 0, 0, 0, 0);
        step(4'b0011, '0, '0, '0,      '0, CMD_ACT, 0, "rrd_c0");
        step(4'b0010, '0, '0, '0,      '0, CMD_NOP, 0, "rrd_c1");
        step(4'b0010, '0, '0, 4'b0100, '0, CMD_PRE, 2, "rrd_pre_bypass");
        step(4'b0010, '0, '0, '0,      '0, CMD_NOP, 0, "rrd_c3");
        step(4'b0010, '0, '0, '0,      '0, CMD_ACT, 1, "rrd_c4");
        step('0,      '0, '0, '0,      '0, CMD_NOP, 0, "rrd_flush");

        // tWTR=5, tCCD=1: RD behind a WR is granted at cycle 6.
        do_reset();
        set_tim(0, 1, 5, 0, 0);
        step('0, 4'b0010, 4'b0001, '0, '0, CMD_WR, 0, "wtr_c0");
        for (int c = 1; c < 6; c++)
            step('0, 4'b0010, '0, '0, '0, CMD_NOP, 0, $sformatf("wtr_c%0d", c));
        step('0, 4'b0010, '0, '0, '0, CMD_RD, 1, "wtr_c6");
        step('0, '0, '0, '0, '0, CMD_NOP, 0, "wtr_flush");

        // Continuous RD from banks 1 and 2 alternates.
        do_reset();
        set_tim(0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++)
            step('0, 4'b0110, '0, '0, '0, CMD_RD, (c % 2 == 0) ? 1 : 2, $sformatf("alt_c%0d", c));
        step('0, '0, '0, '0, '0, CMD_NOP, 0, "alt_flush");

        // RD beats ACT, ACT follows next cycle.
        do_reset();
        step(4'b0001, 4'b0100, '0, '0, '0, CMD_RD,  2, "prio_rd");
        step(4'b0001, '0,      '0, '0, '0, CMD_ACT, 0, "prio_act");
        step('0,      '0,      '0, '0, '0, CMD_NOP, 0, "prio_flush");

        // Reset right after a WR grant drops the pending command and counters.
        do_reset();
        set_tim(0, 0, 5, 0, 0);
        step('0, '0, 4'b0001, '0, '0, CMD_WR, 0, "mid_wr");
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_req('0, '0, '0, '0, '0);
        #1;
        check("mid_rst_valid", 64'({cmd_valid, cmd}), 64'(CMD_NOP));
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step('0, 4'b0001, '0, '0, '0, CMD_RD, 0, "post_rst_rd");
        step('0, '0, '0, '0, '0, CMD_NOP, 0, "post_rst_flush");

`ifdef SAL_TFAW_EN
        // tFAW=15, four slots: fifth ACT waits until cycle 16.
        do_reset();
        set_tim(0, 0, 0, 0, 15);
        for (int c = 0; c <= 16; c++) begin
            if (c < 4)
                step(4'b1111, '0, '0, '0, '0, CMD_ACT, c, $sformatf("faw_c%0d", c));
            else if (c == 16)
                step(4'b1111, '0, '0, '0, '0, CMD_ACT, 0, "faw_c16");
            else
                step(4'b1111, '0, '0, '0, '0, CMD_NOP, 0, $sformatf("faw_c%0d", c));
        end
        step('0, '0, '0, '0, '0, CMD_NOP, 0, "faw_flush");
`endif

        check("sbq_drained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sal_cmd_sched.md
SAL_CMD_SCHED -- requirements
Module: SAL_CMD_SCHED

Interface
REQ-001 Parameter NUM_BANKS, default 4, number of bank controllers served.
REQ-002 Parameter FAW_DEPTH, default 4, activates allowed per tFAW window.
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 timing_if  TIMING_IF.MON  -  supplies t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1, t_faw_m1.
REQ-006 sched_if[NUM_BANKS]  SCHED_IF.DST  -  per-bank inputs act/rd/wr/pre/ref_req, ba, ra, ca, id, len; outputs act/rd/wr/pre/ref_gnt.
REQ-007 cmd_valid_o  output  1  registered DRAM command valid.
REQ-008 cmd_o  output  dram_cmd_t  command type: ACT, RD, WR, PRE, REF.
REQ-009 cmd_ba_o, cmd_ra_o, cmd_ca_o, cmd_id_o, cmd_len_o  output  package types  registered fields of the issued command.

Function
REQ-010 Grants SHALL be combinational from the current requests and registered state, asserted in the same cycle as the request.
REQ-011 At most one grant SHALL be asserted across all banks and all command types in any cycle.
REQ-012 Class priority SHALL be RD/WR > ACT > PRE > REF.
REQ-013 Within a class, banks SHALL be arbitrated round-robin, starting from the bank after the last granted bank (rr_ptr).
REQ-014 rr_ptr SHALL update only on a grant; it wraps from NUM_BANKS-1 to 0.
REQ-015 A granted command SHALL appear on cmd_*_o exactly one cycle after the grant, with cmd_valid_o high for one cycle; otherwise cmd_valid_o=0.
REQ-016 On an ACT grant, the tRRD counter SHALL load t_rrd_m1; ACT SHALL be ineligible while the counter is nonzero.
REQ-017 On an RD or WR grant, the tCCD counter SHALL load t_ccd_m1; RD and WR SHALL be ineligible while it is nonzero.
REQ-018 On a WR grant, the tWTR counter SHALL load t_wtr_m1 and block RD while it is nonzero.
REQ-019 On an RD grant, the tRTW counter SHALL load t_rtw_m1 and block WR while it is nonzero.
REQ-020 Counters SHALL decrement by 1 per cycle, saturate at 0, and reload on a new grant even when nonzero.
REQ-021 A class blocked by timing SHALL NOT block lower-priority eligible classes in the same cycle.
REQ-022 REF SHALL be eligible only when no ACT, RD or WR is requested by any bank.
REQ-023 A bank asserting several request types at once SHALL receive at most one grant, following REQ-012.

Reset
REQ-024 While rst_n=0: cmd_valid_o=0, cmd_o=NOP encoding, other cmd_*_o=0, rr_ptr=0, all timing counters=0, all grants=0.
REQ-025 Reset asserted mid-operation SHALL take effect immediately and discard the pending registered command.

Configuration
REQ-026 Macro SAL_TFAW_EN: when defined, FAW_DEPTH countdown slots SHALL be kept; each ACT grant loads t_faw_m1 into a zero slot; ACT SHALL be ineligible while all slots are nonzero.
REQ-027 Without SAL_TFAW_EN, no tFAW logic SHALL exist and t_faw_m1 SHALL be ignored.

Structure
REQ-028 dram_cmd_t, dram_ba_t, dram_ra_t, dram_ca_t, dram_id_t and dram_len_t SHALL live in the shared package SAL_DDR_PKG.
REQ-029 Each timing counter, including the tFAW slots, SHALL be an instance of the existing SAL_TIMING_CNTR; no new sub-module is needed.

Verification
REQ-030 t_rrd_m1=3; banks 0 and 1 request ACT at cycle 0 -> bank0 granted at cycle 0, bank1 at cycle 4; cmd_valid_o at cycles 1 and 5.
REQ-031 t_wtr_m1=5, t_ccd_m1=1; bank0 WR at cycle 0, bank1 RD pending from cycle 0 -> RD granted at cycle 6.
REQ-032 t_ccd_m1=0; banks 1 and 2 hold RD continuously -> grants alternate 1,2,1,2 every cycle.
REQ-033 Bank2 RD and bank0 ACT at the same cycle with all counters 0 -> bank2 RD granted, ACT granted the next cycle.
REQ-034 SAL_TFAW_EN, t_rrd_m1=0, t_faw_m1=15; 5 ACTs requested back-to-back from cycle 0 -> first four at cycles 0-3, fifth at cycle 16.
REQ-035 rst_n dropped the cycle after a WR grant -> cmd_valid_o stays 0 and counters are 0; after release, RD is granted immediately.
